pwm_output_stage: RTL and testbench

Per-channel PWM output generator that sits directly downstream of the channel comparator. It consumes the registered start/end equality flags and drives one PWM output pin through an edge-driven ON/OFF state machine. It applies shadowed full-on, full-off, polarity and one-pulse controls, and reports completed pulses. It runs in the prescaler clock domain alongside the counter and comparator.

---
 rtl/pwm_output_stage.sv | 173 +++++++++++++++++
 tb/tb_pwm_output_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_output_stage.sv
// pwm_output_stage: per-channel PWM output generator.
// Consumes the registered CNT==CMP_START / CNT==CMP_END flags from the
// channel comparator and drives one PWM pin through an IDLE/OFF/ON/DONE
// state machine. Full-on, full-off, polarity and one-pulse controls are
// shadowed and only take effect after an update event. Completed pulses
// are reported as a one-cycle strobe and a saturating count.
module pwm_output_stage #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_psc_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             update_event_i,
    input  logic             cnt_eq_cmp_start_i,
    input  logic             cnt_eq_cmp_end_i,
    input  logic             full_on_i,
    input  logic             full_off_i,
    input  logic             polarity_i,
    input  logic             one_pulse_i,
    output logic             pwm_o,
    output logic             active_o,
    output logic             pulse_done_o,
    output logic [CNT_W-1:0] pulse_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OFF  = 2'd1,
        ST_ON   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e           state_q,       state_d;
    logic             full_on_sh_q,  full_on_sh_d;
    logic             full_off_sh_q, full_off_sh_d;
    logic             pol_sh_q,      pol_sh_d;
    logic             op_sh_q,       op_sh_d;
    logic             pwm_q,         pwm_d;
    logic             active_q,      active_d;
    logic             pulse_done_q,  pulse_done_d;
    logic [CNT_W-1:0] pulse_cnt_q,   pulse_cnt_d;
    logic             lvl_d;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    // Shadow configuration: capture the preload inputs only on an update event.
    always_comb begin
        full_on_sh_d  = full_on_sh_q;
        full_off_sh_d = full_off_sh_q;
        pol_sh_d      = pol_sh_q;
        op_sh_d       = op_sh_q;
        if (update_event_i) begin
            full_on_sh_d  = full_on_i;
            full_off_sh_d = full_off_i;
            pol_sh_d      = polarity_i;
            op_sh_d       = one_pulse_i;
        end else begin
            full_on_sh_d  = full_on_sh_q;
            full_off_sh_d = full_off_sh_q;
            pol_sh_d      = pol_sh_q;
            op_sh_d       = op_sh_q;
        end
    end

    // Next-state logic; disable wins over everything, end match wins over start match.
    always_comb begin
        state_d      = state_q;
        pulse_done_d = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Never resume mid-window: wait in OFF for the next start match.
                    state_d = ST_OFF;
                end
                ST_OFF: begin
                    // Start and end on the same count means 0% duty.
                    if (cnt_eq_cmp_start_i && !cnt_eq_cmp_end_i) begin
                        state_d = ST_ON;
                    end else begin
                        state_d = ST_OFF;
                    end
                end
                ST_ON: begin
                    // Old op_sh is used even if an update event lands on this edge.
                    if (cnt_eq_cmp_end_i) begin
                        state_d      = op_sh_q ? ST_DONE : ST_OFF;
                        pulse_done_d = 1'b1;
                    end else begin
                        state_d = ST_ON;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Completed-pulse counter: clears on re-enable, saturates at all-ones.
    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        if ((state_q == ST_IDLE) && (state_d == ST_OFF)) begin
            pulse_cnt_d = CNT_ZERO;
        end else if (pulse_done_d) begin
            pulse_cnt_d = sat_inc(pulse_cnt_q);
        end else begin
            pulse_cnt_d = pulse_cnt_q;
        end
    end

    // Output level from the next state so pwm_o, active_o and pulse_done_o move on the same edge.
    always_comb begin
        lvl_d = 1'b0;
        if (state_d == ST_IDLE) begin
            lvl_d = 1'b0;
        end else if (full_off_sh_q) begin
            lvl_d = 1'b0;
        end else if (full_on_sh_q) begin
            lvl_d = 1'b1;
        end else begin
            lvl_d = (state_d == ST_ON);
        end
        pwm_d    = lvl_d ^ pol_sh_q;
        active_d = (state_d == ST_ON);
    end

    // State, shadow and output registers with synchronous reset.
    always_ff @(posedge clk_psc_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            full_on_sh_q  <= 1'b0;
            full_off_sh_q <= 1'b0;
            pol_sh_q      <= 1'b0;
            op_sh_q       <= 1'b0;
            pwm_q         <= 1'b0;
            active_q      <= 1'b0;
            pulse_done_q  <= 1'b0;
            pulse_cnt_q   <= CNT_ZERO;
        end else begin
            state_q       <= state_d;
            full_on_sh_q  <= full_on_sh_d;
            full_off_sh_q <= full_off_sh_d;
            pol_sh_q      <= pol_sh_d;
            op_sh_q       <= op_sh_d;
            pwm_q         <= pwm_d;
            active_q      <= active_d;
            pulse_done_q  <= pulse_done_d;
            pulse_cnt_q   <= pulse_cnt_d;
        end
    end

    assign pwm_o        = pwm_q;
    assign active_o     = active_q;
    assign pulse_done_o = pulse_done_q;
    assign pulse_cnt_o  = pulse_cnt_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Self-checking bench for pwm_output_stage. The bench owns a free-running
// counter and produces the registered comparator flags itself. Two DUTs
// (CNT_W=8 and CNT_W=2) share all inputs so saturation is exercised too.
module tb_pwm_output_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, upd, eqs, eqe, fon, foff, pol, op;
    logic pwm, act, done;
    logic [7:0] cnt8;
    logic pwm2, act2, done2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    // bench counter / comparator settings
    int cnt_v   = 0;
    int period  = 10;
    int start_v = 2;
    int end_v   = 6;

    // reference model state
    bit m_live, m_in, m_fin;
    int m_c8, m_c2;
    bit m_fon, m_foff, m_pol, m_op;
    bit e_pwm, e_act, e_done;

    pwm_output_stage #(.CNT_W(8)) dut (
        .clk_psc_i(clk), .rst_i(rst), .enable_i(en), .update_event_i(upd),
        .cnt_eq_cmp_start_i(eqs), .cnt_eq_cmp_end_i(eqe),
        .full_on_i(fon), .full_off_i(foff), .polarity_i(pol), .one_pulse_i(op),
        .pwm_o(pwm), .active_o(act), .pulse_done_o(done), .pulse_cnt_o(cnt8)
    );

    pwm_output_stage #(.CNT_W(2)) dut2 (
        .clk_psc_i(clk), .rst_i(rst), .enable_i(en), .update_event_i(upd),
        .cnt_eq_cmp_start_i(eqs), .cnt_eq_cmp_end_i(eqe),
        .full_on_i(fon), .full_off_i(foff), .polarity_i(pol), .one_pulse_i(op),
        .pwm_o(pwm2), .active_o(act2), .pulse_done_o(done2), .pulse_cnt_o(cnt2)
    );

    function automatic logic [15:0] obs();
        obs = {pwm, act, done, cnt8, pwm2, act2, done2, cnt2};
    endfunction

    function automatic logic [15:0] mdl();
        mdl = {e_pwm, e_act, e_done, 8'(m_c8), e_pwm, e_act, e_done, 2'(m_c2)};
    endfunction

    // One clock: advance the model with the inputs the DUT sampled, then
    // produce the next comparator flags from the bench counter.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_live = 0; m_in = 0; m_fin = 0; m_c8 = 0; m_c2 = 0;
            m_fon = 0; m_foff = 0; m_pol = 0; m_op = 0;
            e_pwm = 0; e_act = 0; e_done = 0;
        end else begin
            e_done = 0;
            if (!en) begin
                m_in = 0; m_fin = 0;
            end else if (!m_live) begin
                m_in = 0; m_fin = 0; m_c8 = 0; m_c2 = 0;
            end else if (m_in) begin
                if (eqe) begin
                    e_done = 1;
                    m_in   = 0;
                    m_fin  = m_op;
                    m_c8   = (m_c8 < 255) ? m_c8 + 1 : 255;
                    m_c2   = (m_c2 < 3) ? m_c2 + 1 : 3;
                end
            end else if (!m_fin && eqs && !eqe) begin
                m_in = 1;
            end
            m_live = en;
            e_act  = m_in;
            e_pwm  = (!m_live ? 1'b0 : m_foff ? 1'b0 : m_fon ? 1'b1 : m_in) ^ m_pol;
            if (upd) begin
                m_fon = fon; m_foff = foff; m_pol = pol; m_op = op;
            end
        end
        #1;
        eqs   = (cnt_v == start_v);
        eqe   = (cnt_v == end_v);
        cnt_v = (cnt_v + 1) % period;
    endtask

    task automatic restart_counter();
        cnt_v = 0; eqs = 1'b0; eqe = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (obs() !== 16'h0000)
            begin errors++; $display("FAIL reset_outputs got=%h exp=%h", obs(), 16'h0000); end
        rst = 1'b0;
        step();
        checks++;
        if (obs() !== mdl())
            begin errors++; $display("FAIL reset_idle got=%h exp=%h", obs(), mdl()); end
    endtask

    task automatic test_basic_duty();
        int highs = 0;
        int rise = -1;
        int fall = -1;
        start_v = 2; end_v = 6; period = 10;
        restart_counter();
        en = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            step();
            checks++;
            if (obs() !== mdl())
                begin errors++; $display("FAIL basic_model cyc=%0d got=%h exp=%h", i, obs(), mdl()); end
            if (pwm) highs++;
            if (pwm && rise < 0) rise = i;
            if (!pwm && rise >= 0 && fall < 0) fall = i;
        end
        checks++;
        if (rise != 4 || fall != 8)
            begin errors++; $display("FAIL basic_edges got=%0d/%0d exp=4/8", rise, fall); end
        checks++;
        if (highs != 12)
            begin errors++; $display("FAIL basic_high_cycles got=%0d exp=12", highs); end
        checks++;
        if (cnt8 !== 8'd3)
            begin errors++; $display("FAIL basic_pulse_cnt got=%0d exp=3", cnt8); end
    endtask

    task automatic test_wrap_zero();
        int highs = 0;
        int dones = 0;
        en = 1'b0;
        step();
        start_v = 8; end_v = 3; period = 10;
        restart_counter();
        en = 1'b1;
        for (int i = 1; i <= 28; i++) begin
            step();
            checks++;
            if (obs() !== mdl())
                begin errors++; $display("FAIL wrap_model cyc=%0d got=%h exp=%h", i, obs(), mdl()); end
            if (pwm) highs++;
        end
        checks++;
        if (highs != 10)
            begin errors++; $display("FAIL wrap_high_cycles got=%0d exp=10", highs); end
        start_v = 5; end_v = 5;
        upd = 1'b1;
        step();
        upd = 1'b0;
        highs = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (obs() !== mdl())
                begin errors++; $display("FAIL zero_model cyc=%0d got=%h exp=%h", i, obs(), mdl()); end
            if (pwm) highs++;
            if (done) dones++;
        end
        checks++;
        if (highs != 0 || dones != 0)
            begin errors++; $display("FAIL zero_duty got=%0d/%0d exp=0/0", highs, dones); end
    endtask

    task automatic test_overrides();
        int ones = 0;
        int bad = 0;
        start_v = 2; end_v = 6; period = 10;
        restart_counter();
        en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        fon = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (obs() !== mdl())
                begin errors++; $display("FAIL ovr_preload_model cyc=%0d got=%h exp=%h", i, obs(), mdl()); end
        end
        upd = 1'b1; step(); upd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pwm) ones++;
        end
        checks++;
        if (ones != 10)
            begin errors++; $display("FAIL ovr_full_on got=%0d exp=10", ones); end
        foff = 1'b1;
        upd = 1'b1; step(); upd = 1'b0;
        ones = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pwm) ones++;
        end
        checks++;
        if (ones != 0)
            begin errors++; $display("FAIL ovr_full_off got=%0d exp=0", ones); end
        fon = 1'b0; foff = 1'b0; pol = 1'b1;
        upd = 1'b1; step(); upd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pwm !== ~act) bad++;
        end
        checks++;
        if (bad != 0)
            begin errors++; $display("FAIL ovr_polarity got=%0d exp=0 bad cycles", bad); end
        en = 1'b0;
        step();
        checks++;
        if (pwm !== 1'b1)
            begin errors++; $display("FAIL ovr_idle_level got=%b exp=1", pwm); end
        checks++;
        if (obs() !== mdl())
            begin errors++; $display("FAIL ovr_idle_model got=%h exp=%h", obs(), mdl()); end
        pol = 1'b0;
        upd = 1'b1; step(); upd = 1'b0;
    endtask

    task automatic test_one_pulse();
        int dones = 0;
        op = 1'b1;
        upd = 1'b1; step(); upd = 1'b0;
        start_v = 2; end_v = 6; period = 10;
        restart_counter();
        en = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            checks++;
            if (obs() !== mdl())
                begin errors++; $display("FAIL op_model cyc=%0d got=%h exp=%h", i, obs(), mdl()); end
            if (done) dones++;
        end
        checks++;
        if (dones != 1 || cnt8 !== 8'd1 || act !== 1'b0)
            begin errors++; $display("FAIL op_single got=%0d/%0d/%b exp=1/1/0", dones, cnt8, act); end
        en = 1'b0; step();
        en = 1'b1; step();
        checks++;
        if (cnt8 !== 8'd0)
            begin errors++; $display("FAIL op_reenable_clear got=%0d exp=0", cnt8); end
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done) dones++;
        end
        checks++;
        if (dones != 1 || cnt8 !== 8'd1)
            begin errors++; $display("FAIL op_second got=%0d/%0d exp=1/1", dones, cnt8); end
        op = 1'b0;
        upd = 1'b1; step(); upd = 1'b0;
    endtask

    task automatic test_saturation();
        int dones2 = 0;
        en = 1'b0; step();
        start_v = 2; end_v = 6; period = 10;
        restart_counter();
        en = 1'b1;
        for (int i = 1; i <= 63; i++) begin
            step();
            checks++;
            if (obs() !== mdl())
                begin errors++; $display("FAIL sat_model cyc=%0d got=%h exp=%h", i, obs(), mdl()); end
            if (done2) dones2++;
        end
        checks++;
        if (dones2 != 6 || cnt2 !== 2'd3 || cnt8 !== 8'd6)
            begin errors++; $display("FAIL sat_limit got=%0d/%0d/%0d exp=6/3/6", dones2, cnt2, cnt8); end
    endtask

    task automatic test_mid_reset_disable();
        int dones = 0;
        int guard = 0;
        while (act !== 1'b1 && guard < 40) begin step(); guard++; end
        checks++;
        if (act !== 1'b1)
            begin errors++; $display("FAIL mid_wait_on got=%b exp=1", act); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if (obs() !== 16'h0000)
            begin errors++; $display("FAIL mid_reset got=%h exp=%h", obs(), 16'h0000); end
        guard = 0;
        while (act !== 1'b1 && guard < 40) begin step(); guard++; end
        checks++;
        if (act !== 1'b1)
            begin errors++; $display("FAIL mid_wait_on2 got=%b exp=1", act); end
        en = 1'b0;
        step();
        checks++;
        if ({pwm, act, done} !== 3'b000)
            begin errors++; $display("FAIL mid_disable got=%b exp=000", {pwm, act, done}); end
        for (int i = 0; i < 15; i++) begin
            step();
            if (done) dones++;
        end
        checks++;
        if (dones != 0)
            begin errors++; $display("FAIL mid_no_done got=%0d exp=0", dones); end
    endtask

    task automatic test_random();
        en = 1'b1;
        for (int i = 1; i <= 800; i++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            rst  = ($urandom_range(0, 199) == 0);
            upd  = ($urandom_range(0, 9) == 0);
            fon  = 1'($urandom_range(0, 1));
            foff = ($urandom_range(0, 3) == 0);
            pol  = 1'($urandom_range(0, 1));
            op   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                period  = $urandom_range(4, 12);
                start_v = $urandom_range(0, period - 1);
                end_v   = $urandom_range(0, period - 1);
                cnt_v   = cnt_v % period;
            end
            step();
            checks++;
            if (obs() !== mdl())
                begin errors++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs(), mdl()); end
        end
        rst = 1'b0; upd = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; upd = 1'b0; eqs = 1'b0; eqe = 1'b0;
        fon = 1'b0; foff = 1'b0; pol = 1'b0; op = 1'b0;
        test_reset();
        test_basic_duty();
        test_wrap_zero();
        test_overrides();
        test_one_pulse();
        test_saturation();
        test_mid_reset_disable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
